mem_bus_router: RTL and testbench

Parametrised successor to the fixed-map address decoder on the multicycle RISC-V data bus. Decodes each CPU bus request against N programmable base/mask regions and drives a one-hot select to the matching peripheral. Sequences the access through a small FSM and returns the selected slave's read data with a single-cycle ready pulse. Unmapped addresses and slaves that never answer are reported as bus errors instead of hanging the core.

---
 rtl/mem_bus_router_if.sv | 41 ++++
 rtl/mem_bus_router.sv | 183 ++++++++++++++++++
 tb/tb_mem_bus_router.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_router_if.sv
// mem_bus_router_if: CPU-side request/response bus plus the slave-side
// fan-out of the data-bus router, bundled so the router and its
// environment share one set of widths.
//   master modport : CPU + slave models (drive request, slave read data/ready)
//   slave  modport : the router (consumes request, drives response and selects)
interface mem_bus_router_if #(
    parameter int unsigned N_REGIONS = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
);
    // CPU request/response
    logic                        req_i;
    logic                        we_i;
    logic [ADDR_W-1:0]           addr_i;
    logic [DATA_W-1:0]           wdata_i;
    logic [DATA_W-1:0]           rdata_o;
    logic                        ready_o;
    logic                        err_o;
    logic                        busy_o;
    // slave fan-out
    logic [N_REGIONS-1:0]        sel_o;
    logic [ADDR_W-1:0]           s_addr_o;
    logic                        s_we_o;
    logic [DATA_W-1:0]           s_wdata_o;
    logic [N_REGIONS*DATA_W-1:0] s_rdata_i;
    logic [N_REGIONS-1:0]        s_ready_i;
    // fault reporting
    logic [ADDR_W-1:0]           err_addr_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, s_rdata_i, s_ready_i,
        input  rdata_o, ready_o, err_o, busy_o, sel_o, s_addr_o, s_we_o,
               s_wdata_o, err_addr_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, s_rdata_i, s_ready_i,
        output rdata_o, ready_o, err_o, busy_o, sel_o, s_addr_o, s_we_o,
               s_wdata_o, err_addr_o
    );
endinterface

// File: rtl/mem_bus_router.sv
// mem_bus_router: decodes CPU data-bus requests against N_REGIONS
// base/mask windows, drives a one-hot slave select through an ACCESS phase
// and returns the slave's read data with a one-cycle ready pulse. Unmapped
// addresses and slaves silent for more than TIMEOUT wait cycles complete
// with err_o.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - asynchronous active-low reset
//   bus    - mem_bus_router_if.slave (request, response, slave fan-out,
//            err_addr_o)
// Optional feature macro: BUS_ERR_CAPTURE_EN (err_addr_o records the address
// of the last faulting access; otherwise err_addr_o is tied to 0).
module mem_bus_router #(
    parameter int unsigned N_REGIONS = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE =
        {32'h70000000, 32'h60000000, 32'h50000000, 32'h80000000},
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_MASK =
        {32'hFFFFF000, 32'hFFFFF000, 32'hFFFFF000, 32'hE0000000},
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    mem_bus_router_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam logic [1:0] ST_ERR    = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [N_REGIONS-1:0] sel_q, sel_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 we_q, we_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 ready_q, ready_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [N_REGIONS-1:0] dec_sel;
    logic                 dec_found;
    logic                 acc_ready;
    logic [DATA_W-1:0]    acc_rdata;

    // Region decode of the incoming address; lowest matching index wins.
    always_comb begin
        dec_sel   = '0;
        dec_found = 1'b0;
        for (int i = 0; i < int'(N_REGIONS); i++) begin
            if (!dec_found &&
                ((bus.addr_i & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
                 REGION_BASE[i*ADDR_W +: ADDR_W])) begin
                dec_sel[i] = 1'b1;
                dec_found  = 1'b1;
            end
        end
    end

    // Only the selected slave's ready and read data are observed.
    assign acc_ready = |(bus.s_ready_i & sel_q);

    always_comb begin
        acc_rdata = '0;
        for (int i = 0; i < int'(N_REGIONS); i++) begin
            if (sel_q[i]) begin
                acc_rdata = acc_rdata | bus.s_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and next registered outputs; ready/err/rdata are produced
    // on the transition so they appear in the RESP/ERR cycle itself.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = '0;
        ready_d = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_i) begin
                    addr_d  = bus.addr_i;
                    we_d    = bus.we_i;
                    wdata_d = bus.wdata_i;
                    cnt_d   = '0;
                    if (dec_found) begin
                        sel_d   = dec_sel;
                        state_d = ST_ACCESS;
                    end else begin
                        sel_d   = '0;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
            end
            ST_ACCESS: begin
                if (acc_ready) begin
                    sel_d   = '0;
                    ready_d = 1'b1;
                    rdata_d = we_q ? '0 : acc_rdata;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    sel_d   = '0;
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.rdata_o   = rdata_q;
    assign bus.ready_o   = ready_q;
    assign bus.err_o     = err_q;
    assign bus.busy_o    = (state_q != ST_IDLE);
    assign bus.sel_o     = sel_q;
    assign bus.s_addr_o  = addr_q;
    assign bus.s_we_o    = we_q;
    assign bus.s_wdata_o = wdata_q;

`ifdef BUS_ERR_CAPTURE_EN
    // Faulting address; addr_d already carries the newly latched address
    // for unmapped requests and the held address for timeouts.
    logic [ADDR_W-1:0] err_addr_q;
    logic              err_entry;

    assign err_entry = (state_d == ST_ERR) && (state_q != ST_ERR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_addr_q <= '0;
        end else if (err_entry) begin
            err_addr_q <= addr_d;
        end
    end

    assign bus.err_addr_o = err_addr_q;
`else
    assign bus.err_addr_o = '0;
`endif

endmodule

// File: tb/tb_mem_bus_router.sv
// tb_mem_bus_router: directed transactions against mem_bus_router. A
// transaction-level model expands each request into the per-cycle outputs
// the router must show; one compare process checks them on every falling
// edge, and literal expectations pin decode, latency and data.
module tb_mem_bus_router;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int          TO = 15;

`ifdef BUS_ERR_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    localparam logic [31:0] M_BASE [4] = '{32'h80000000, 32'h50000000, 32'h60000000, 32'h70000000};
    localparam logic [31:0] M_MASK [4] = '{32'hE0000000, 32'hFFFFF000, 32'hFFFFF000, 32'hFFFFF000};

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic        err;
        logic        s_we;
        logic [3:0]  sel;
        logic [31:0] rdata;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        logic [31:0] err_addr;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_bus_router_if #(.N_REGIONS(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_bus_router #(.N_REGIONS(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int   checks = 0;
    int   errors = 0;
    obs_t exp_o;
    bit   exp_on = 1'b0;

    // model state: what the slave-side latches must hold
    logic [31:0] m_addr = '0, m_wdata = '0, m_err_addr = '0;
    logic        m_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int model_decode(input logic [31:0] a);
        for (int i = 0; i < 4; i++) if ((a & M_MASK[i]) == M_BASE[i]) return i;
        return -1;
    endfunction

    function automatic obs_t idle_obs();
        obs_t o;
        o          = '0;
        o.s_addr   = m_addr;
        o.s_we     = m_we;
        o.s_wdata  = m_wdata;
        o.err_addr = CAP ? m_err_addr : 32'h0;
        return o;
    endfunction

    // each slave presents distinct data so a wrong mux shows up
    function automatic logic [127:0] fill(input int region, input logic [31:0] data);
        logic [127:0] v;
        for (int j = 0; j < 4; j++)
            v[j*32 +: 32] = (j == region) ? data : (data ^ (32'h11111111 * 32'(j + 1)));
        return v;
    endfunction

    // single compare process
    always @(negedge clk) begin
        if (exp_on) begin
            chk("busy",     32'(bus.busy_o),    32'(exp_o.busy));
            chk("ready",    32'(bus.ready_o),   32'(exp_o.ready));
            chk("err",      32'(bus.err_o),     32'(exp_o.err));
            chk("sel",      32'(bus.sel_o),     32'(exp_o.sel));
            chk("rdata",    bus.rdata_o,        exp_o.rdata);
            chk("s_addr",   bus.s_addr_o,       exp_o.s_addr);
            chk("s_we",     32'(bus.s_we_o),    32'(exp_o.s_we));
            chk("s_wdata",  bus.s_wdata_o,      exp_o.s_wdata);
            chk("err_addr", bus.err_addr_o,     exp_o.err_addr);
        end
    end

    // One request; lat = ACCESS cycle index where the selected slave answers
    // (lat > TO means never). Returns cycle offset of ready_o as seen on the bus.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input int lat, input logic [31:0] data, input bit noise,
                           input bit hold_req, output int resp_at, output bit got_err,
                           output logic [31:0] got_rdata);
        int   region, nacc;
        bit   is_err;
        obs_t e;
        region = model_decode(addr);
        nacc   = (region < 0) ? 0 : ((lat > TO) ? TO + 1 : lat + 1);
        is_err = (region < 0) || (lat > TO);
        resp_at = -1; got_err = 1'b0; got_rdata = '0;
        for (int c = 0; c < nacc + 3; c++) begin
            if (bus.ready_o === 1'b1 && resp_at < 0) begin
                resp_at   = c;
                got_err   = bus.err_o;
                got_rdata = bus.rdata_o;
            end
            bus.req_i     = 1'b0;
            bus.s_ready_i = '0;
            bus.s_rdata_i = fill(region, data);
            if (c == 0) begin
                bus.req_i   = 1'b1;
                bus.addr_i  = addr;
                bus.we_i    = we;
                bus.wdata_i = wdata;
                e = idle_obs();
            end else begin
                if (c == 1) begin m_addr = addr; m_we = we; m_wdata = wdata; end
                if (c == nacc + 1 && is_err) m_err_addr = addr;
                e = idle_obs();
                if (c <= nacc) begin
                    e.busy = 1'b1;
                    e.sel  = 4'(1 << region);
                    if (c - 1 == lat) bus.s_ready_i[region] = 1'b1;
                    else if (noise)   bus.s_ready_i = ~(4'(1 << region));
                    if (hold_req) begin
                        bus.req_i  = 1'b1;
                        bus.addr_i = 32'h70000004;
                        bus.we_i   = ~we;
                    end
                end else if (c == nacc + 1) begin
                    e.busy  = 1'b1;
                    e.ready = 1'b1;
                    e.err   = is_err;
                    e.rdata = (is_err || we) ? 32'h0 : data;
                end
            end
            exp_o  = e;
            exp_on = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r;
        bit          ge;
        logic [31:0] rd;

        rst_n = 1'b0;
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0;
        bus.s_rdata_i = '0; bus.s_ready_i = '0;
        #12;
        chk("rst_ready",    32'(bus.ready_o), 0);
        chk("rst_err",      32'(bus.err_o),   0);
        chk("rst_busy",     32'(bus.busy_o),  0);
        chk("rst_sel",      32'(bus.sel_o),   0);
        chk("rst_rdata",    bus.rdata_o,      0);
        chk("rst_s_addr",   bus.s_addr_o,     0);
        chk("rst_err_addr", bus.err_addr_o,   0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // pin the model's decode
        chk("pin_dec_80000010", 32'(model_decode(32'h80000010)), 32'h0);
        chk("pin_dec_9FFFFFFC", 32'(model_decode(32'h9FFFFFFC)), 32'h0);
        chk("pin_dec_A0000000", 32'(model_decode(32'hA0000000)), 32'hFFFFFFFF);
        chk("pin_dec_50000FFC", 32'(model_decode(32'h50000FFC)), 32'h1);
        chk("pin_dec_50001000", 32'(model_decode(32'h50001000)), 32'hFFFFFFFF);

        // zero-wait read of region 0
        run_txn(32'h80000010, 1'b0, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1'b0, r, ge, rd);
        chk("t1_latency", 32'(r), 2);
        chk("t1_err",     32'(ge), 0);
        chk("t1_rdata",   rd, 32'hDEADBEEF);

        // write to region 1, three wait cycles, other slaves' ready asserted
        run_txn(32'h50000004, 1'b1, 32'h000000AA, 3, 32'h12345678, 1'b1, 1'b1, r, ge, rd);
        chk("t2_latency", 32'(r), 5);
        chk("t2_err",     32'(ge), 0);
        chk("t2_rdata",   rd, 32'h0);

        // unmapped
        run_txn(32'h40000000, 1'b0, 32'h0, 0, 32'h55555555, 1'b0, 1'b0, r, ge, rd);
        chk("t3_latency", 32'(r), 1);
        chk("t3_err",     32'(ge), 1);
`ifdef BUS_ERR_CAPTURE_EN
        chk("t3_err_addr", bus.err_addr_o, 32'h40000000);
`endif

        // silent slave -> timeout after 16 ACCESS cycles
        run_txn(32'h60000000, 1'b0, 32'h0, 1000, 32'h77777777, 1'b1, 1'b0, r, ge, rd);
        chk("t4_latency", 32'(r), 17);
        chk("t4_err",     32'(ge), 1);
        chk("t4_rdata",   rd, 32'h0);
`ifdef BUS_ERR_CAPTURE_EN
        chk("t4_err_addr", bus.err_addr_o, 32'h60000000);
`endif

        // ready exactly when the counter reaches TIMEOUT
        run_txn(32'h60000010, 1'b0, 32'h0, 15, 32'hCAFEF00D, 1'b0, 1'b0, r, ge, rd);
        chk("t5_latency", 32'(r), 17);
        chk("t5_err",     32'(ge), 0);
        chk("t5_rdata",   rd, 32'hCAFEF00D);

        // reset mid-ACCESS while req_i stays asserted
        bus.req_i = 1'b1; bus.addr_i = 32'h60000100; bus.we_i = 1'b0; bus.wdata_i = 32'h0;
        bus.s_ready_i = '0;
        exp_o = idle_obs();
        @(posedge clk); #1;
        m_addr = 32'h60000100; m_we = 1'b0; m_wdata = 32'h0;
        for (int c = 1; c <= 3; c++) begin
            bus.req_i = 1'b1; bus.addr_i = 32'h80000000;
            bus.s_ready_i = 4'b1011;
            exp_o = idle_obs();
            exp_o.busy = 1'b1;
            exp_o.sel  = 4'b0100;
            @(posedge clk); #1;
        end
        exp_on = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sel",      32'(bus.sel_o),  0);
        chk("mid_rst_busy",     32'(bus.busy_o), 0);
        chk("mid_rst_ready",    32'(bus.ready_o), 0);
        chk("mid_rst_s_addr",   bus.s_addr_o,    0);
        chk("mid_rst_err_addr", bus.err_addr_o,  0);
        bus.req_i = 1'b0; bus.s_ready_i = '0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("in_rst_ready", 32'(bus.ready_o), 0);
        end
        rst_n = 1'b1;
        m_addr = '0; m_we = 1'b0; m_wdata = '0; m_err_addr = '0;
        exp_o  = idle_obs();
        exp_on = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // normal service after reset
        run_txn(32'h70000ABC, 1'b0, 32'h0, 1, 32'h0BADC0DE, 1'b0, 1'b0, r, ge, rd);
        chk("t6_latency", 32'(r), 3);
        chk("t6_err",     32'(ge), 0);
        chk("t6_rdata",   rd, 32'h0BADC0DE);

        exp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
